// File: rtl/image_stream_pkg.sv
// Shared types and default geometry for the image streaming path and the
// spatial filter top.
package image_stream_pkg;

  localparam int unsigned DEFAULT_IMAGE_WIDTH  = 512;
  localparam int unsigned DEFAULT_IMAGE_HEIGHT = 512;
  localparam int unsigned DEFAULT_PIXEL_SIZE   = 32;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT_INTR,
    LINE,
    PAD_WAIT,
    PAD_LINE,
    DONE
  } stream_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO absorbing the one-cycle pixel memory latency in front of
// the AXI-stream output; the head entry is held stable until popped.
module stream_skid_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];

endmodule

// File: rtl/image_line_streamer.sv
// AXI-stream master feeding a raw frame from pixel memory into the spatial
// filter: prime lines, interrupt-paced lines, then zero pad lines.
module image_line_streamer
  import image_stream_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int unsigned PIXEL_SIZE   = DEFAULT_PIXEL_SIZE,
  parameter int unsigned PRIME_LINES  = 4,
  parameter int unsigned PAD_LINES    = 2,
  parameter int unsigned ADDR_WIDTH   = 18
) (
  input  logic                  axis_clk,
  input  logic                  axis_reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [PIXEL_SIZE-1:0] i_mem_rd_data,
  output logic                  o_m_data_valid,
  output logic [PIXEL_SIZE-1:0] o_m_data,
  input  logic                  i_m_ready,
  input  logic                  i_intr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned PRIME_SENT = (IMAGE_HEIGHT < PRIME_LINES) ? IMAGE_HEIGHT : PRIME_LINES;
  localparam int unsigned PW         = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned LW         = $clog2(IMAGE_HEIGHT + PAD_LINES + 1);
  localparam int unsigned IW         = $clog2(PRIME_SENT * IMAGE_WIDTH + 1);

  stream_state_e state_q;
  stream_state_e state_d;

  logic [PW-1:0]         pix_cnt;
  logic [LW-1:0]         line_cnt;
  logic [IW-1:0]         issue_left;
  logic                  intr_q;
  logic                  intr_rise;
  logic                  intr_pending;
  logic                  rd_inflight;

  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [PIXEL_SIZE-1:0] fifo_data;
  logic                  fifo_push;
  logic [PIXEL_SIZE-1:0] fifo_push_data;

  logic                  beat;
  logic                  last_pix;
  logic [2:0]            occ;
  logic                  credit_ok;
  logic                  issue_en;
  logic                  pad_push;
  logic                  wait_state;

  assign beat       = fifo_valid && i_m_ready;
  assign last_pix   = beat && (pix_cnt == PW'(IMAGE_WIDTH - 1));
  assign intr_rise  = i_intr && !intr_q;
  assign wait_state = (state_q == WAIT_INTR) || (state_q == PAD_WAIT);

  // Credit counts the slot freed by a same-cycle pop so 1 pixel/cycle is sustained.
  assign occ       = 3'(fifo_count) + 3'(rd_inflight);
  assign credit_ok = occ < (3'd2 + 3'(beat));
  assign issue_en  = ((state_q == PRIME) || (state_q == LINE)) && (issue_left != '0) && credit_ok;
  assign pad_push  = (state_q == PAD_LINE) && (issue_left != '0) && credit_ok;

  assign fifo_push      = rd_inflight || pad_push;
  assign fifo_push_data = rd_inflight ? i_mem_rd_data : '0;

  stream_skid_fifo #(
    .WIDTH (PIXEL_SIZE)
  ) u_fifo (
    .clk       (axis_clk),
    .rst_n     (axis_reset_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (beat),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .count     (fifo_count)
  );

  assign o_mem_rd_en    = issue_en;
  assign o_m_data_valid = fifo_valid;
  assign o_m_data       = fifo_data;
  assign o_busy         = (state_q != IDLE) && (state_q != DONE);
  assign o_done         = (state_q == DONE);

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = PRIME;
      end
      PRIME: begin
        if (last_pix && (line_cnt == LW'(PRIME_SENT - 1))) begin
          if (PRIME_SENT < IMAGE_HEIGHT) state_d = WAIT_INTR;
          else if (PAD_LINES == 0)       state_d = DONE;
          else                           state_d = PAD_WAIT;
        end
      end
      WAIT_INTR: begin
        if (intr_pending) state_d = LINE;
      end
      LINE: begin
        if (last_pix) begin
          if (line_cnt != LW'(IMAGE_HEIGHT - 1)) state_d = WAIT_INTR;
          else if (PAD_LINES == 0)              state_d = DONE;
          else                                  state_d = PAD_WAIT;
        end
      end
      PAD_WAIT: begin
        if (intr_pending) state_d = PAD_LINE;
      end
      PAD_LINE: begin
        if (last_pix) begin
          if (line_cnt == LW'(IMAGE_HEIGHT + PAD_LINES - 1)) state_d = DONE;
          else                                               state_d = PAD_WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      intr_q       <= 1'b0;
      intr_pending <= 1'b0;
      rd_inflight  <= 1'b0;
      o_mem_addr   <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      issue_left   <= '0;
    end else begin
      intr_q      <= i_intr;
      rd_inflight <= issue_en;

      // A fresh edge arriving on the consuming cycle stays pending.
      if (state_q == IDLE)                 intr_pending <= 1'b0;
      else if (wait_state && intr_pending) intr_pending <= intr_rise;
      else if (intr_rise)                  intr_pending <= 1'b1;

      if ((state_q == IDLE) && i_start) begin
        o_mem_addr <= i_base_addr;
        pix_cnt    <= '0;
        line_cnt   <= '0;
      end else begin
        if (issue_en) o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
        if (beat) begin
          if (last_pix) begin
            pix_cnt  <= '0;
            line_cnt <= line_cnt + LW'(1);
          end else begin
            pix_cnt  <= pix_cnt + PW'(1);
          end
        end
      end

      if (state_d != state_q) begin
        case (state_d)
          PRIME:          issue_left <= IW'(PRIME_SENT * IMAGE_WIDTH);
          LINE, PAD_LINE: issue_left <= IW'(IMAGE_WIDTH);
          default:        issue_left <= '0;
        endcase
      end else if (issue_en || pad_push) begin
        issue_left <= issue_left - IW'(1);
      end
    end
  end

endmodule
